branch_resolver: RTL and testbench

- Resolution end of the branch-prediction loop. Fetch issues predictions from the branch history table; this block consumes them.
- Records each issued prediction in an in-order in-flight queue and compares it against the outcome from execute.
- Drives the BHT training write (en / write_addr / was_taken) back to the table.
- On a mispredict, raises a one-cycle flush with the corrected fetch PC.

---
 rtl/branch_resolver_if.sv | 34 +++
 rtl/branch_resolver.sv | 138 +++++++++++++
 tb/tb_branch_resolver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// rtl/branch_resolver_if.sv - prediction issue, resolution and BHT-training/redirect signal bundle
interface branch_resolver_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 5
);
  // fetch -> resolver: issued predictions
  logic             pred_valid;
  logic             pred_ready;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  // execute -> resolver: outcome of the oldest in-flight branch
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  // resolver -> BHT / fetch: training write and redirect
  logic             bht_en;
  logic [IDX_W-1:0] bht_write_addr;
  logic             bht_was_taken;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, bht_en, bht_write_addr, bht_was_taken, flush, redirect_pc
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, bht_en, bht_write_addr, bht_was_taken, flush, redirect_pc
  );
endinterface

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order branch resolution queue with BHT training and mispredict flush (optional BRANCH_STATS_EN counters)
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_resolver_if.slave       br,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                   underflow_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]            stat_resolved,
  output logic [31:0]            stat_mispred
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, cnt_next;

  logic [PC_W-1:0]  q_pc     [DEPTH];
  logic             q_taken  [DEPTH];
  logic [PC_W-1:0]  q_target [DEPTH];

  logic             pred_ready_q;
  logic             bht_en_q;
  logic [IDX_W-1:0] bht_addr_q;
  logic             bht_taken_q;
  logic             flush_q;
  logic [PC_W-1:0]  redirect_q;
  logic             underflow_q;

  logic             do_push, do_pop, mispredict, underflow_hit;
  logic [PC_W-1:0]  head_pc, head_target;
  logic             head_taken;

  assign head_pc     = q_pc[rd_ptr];
  assign head_taken  = q_taken[rd_ptr];
  assign head_target = q_target[rd_ptr];

  // Decode this cycle's push/pop/mispredict and the next queue state
  always_comb begin
    do_push       = br.pred_valid && pred_ready_q && (state == S_RUN);
    do_pop        = br.res_valid && (state == S_RUN) && (count != '0);
    underflow_hit = br.res_valid && (state == S_RUN) && (count == '0);
    mispredict    = do_pop && ((head_taken != br.res_taken) ||
                               (br.res_taken && (head_target != br.res_target)));
    state_next    = mispredict ? S_FLUSH : S_RUN;
    cnt_next      = count;
    if (mispredict)
      cnt_next = '0;
    else if (do_push && !do_pop)
      cnt_next = count + 1'b1;
    else if (!do_push && do_pop)
      cnt_next = count - 1'b1;
  end

  // Entry storage; a push coinciding with a mispredict is squashed with the rest
  always_ff @(posedge clk) begin
    if (do_push && !mispredict) begin
      q_pc[wr_ptr]     <= br.pred_pc;
      q_taken[wr_ptr]  <= br.pred_taken;
      q_target[wr_ptr] <= br.pred_target;
    end
  end

  // RUN/FLUSH state, queue pointers and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      pred_ready_q <= 1'b0;
      bht_en_q     <= 1'b0;
      bht_addr_q   <= '0;
      bht_taken_q  <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= cnt_next;
      pred_ready_q <= (cnt_next < DEPTH_C) && (state_next == S_RUN);
      if (mispredict) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
      end
      bht_en_q <= do_pop;
      if (do_pop) begin
        bht_addr_q  <= head_pc[IDX_W+1:2];
        bht_taken_q <= br.res_taken;
      end
      flush_q <= mispredict;
      if (mispredict)
        redirect_q <= br.res_taken ? br.res_target : head_pc + PC_STEP;
      if (underflow_hit)
        underflow_q <= 1'b1;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating resolution / mispredict counters, updated on the pop edge
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (do_pop && (stat_resolved != 32'hFFFF_FFFF))
        stat_resolved <= stat_resolved + 32'd1;
      if (mispredict && (stat_mispred != 32'hFFFF_FFFF))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

  assign br.pred_ready     = pred_ready_q;
  assign br.bht_en         = bht_en_q;
  assign br.bht_write_addr = bht_addr_q;
  assign br.bht_was_taken  = bht_taken_q;
  assign br.flush          = flush_q;
  assign br.redirect_pc    = redirect_q;
  assign inflight          = count;
  assign underflow_err     = underflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int IDX_W = 5;

  logic clk;
  logic rst;
  logic [$clog2(DEPTH):0] inflight;
  logic underflow_err;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  branch_resolver_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bif ();

  branch_resolver #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .br            (bif.slave),
    .inflight      (inflight),
    .underflow_err (underflow_err)
`ifdef BRANCH_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bif.pred_valid  = 1'b1;
    bif.pred_pc     = pc;
    bif.pred_taken  = tk;
    bif.pred_target = tgt;
    tick();
    bif.pred_valid  = 1'b0;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    bif.res_valid  = 1'b1;
    bif.res_taken  = tk;
    bif.res_target = tgt;
    tick();
    bif.res_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.pred_valid = 0; bif.pred_pc = 0; bif.pred_taken = 0; bif.pred_target = 0;
    bif.res_valid = 0; bif.res_taken = 0; bif.res_target = 0;
    tick();
    tick();
    chk("rst_pred_ready", 32'(bif.pred_ready), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_bht_en", 32'(bif.bht_en), 0);
    chk("rst_flush", 32'(bif.flush), 0);
    chk("rst_underflow", 32'(underflow_err), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_pred_ready", 32'(bif.pred_ready), 1);
  endtask

  task automatic test_correct();
    push(32'h40, 1'b1, 32'h80);
    chk("corr_inflight_push", 32'(inflight), 1);
    resolve(1'b1, 32'h80);
    chk("corr_bht_en", 32'(bif.bht_en), 1);
    chk("corr_addr", 32'(bif.bht_write_addr), 16);
    chk("corr_was_taken", 32'(bif.bht_was_taken), 1);
    chk("corr_flush", 32'(bif.flush), 0);
    chk("corr_inflight", 32'(inflight), 0);
    tick();
    chk("corr_bht_en_pulse", 32'(bif.bht_en), 0);
  endtask

  task automatic test_mispredict();
    push(32'h10, 1'b0, 32'h0);
    resolve(1'b1, 32'h100);
    chk("dir_bht_en", 32'(bif.bht_en), 1);
    chk("dir_addr", 32'(bif.bht_write_addr), 4);
    chk("dir_was_taken", 32'(bif.bht_was_taken), 1);
    chk("dir_flush", 32'(bif.flush), 1);
    chk("dir_redirect", bif.redirect_pc, 32'h100);
    chk("dir_pred_ready", 32'(bif.pred_ready), 0);
    tick();
    chk("dir_flush_pulse", 32'(bif.flush), 0);
    chk("dir_ready_back", 32'(bif.pred_ready), 1);
    push(32'h20, 1'b1, 32'h60);
    resolve(1'b1, 32'h64);
    chk("tgt_flush", 32'(bif.flush), 1);
    chk("tgt_redirect", bif.redirect_pc, 32'h64);
    chk("tgt_addr", 32'(bif.bht_write_addr), 8);
    tick();
    push(32'h24, 1'b1, 32'h60);
    resolve(1'b0, 32'h0);
    chk("nt_flush", 32'(bif.flush), 1);
    chk("nt_redirect", bif.redirect_pc, 32'h28);
    chk("nt_was_taken", 32'(bif.bht_was_taken), 0);
    chk("nt_addr", 32'(bif.bht_write_addr), 9);
    tick();
    // push coinciding with a mispredicting pop is dropped
    push(32'h30, 1'b1, 32'h90);
    bif.pred_valid = 1'b1; bif.pred_pc = 32'h34; bif.pred_taken = 1'b0;
    bif.res_valid = 1'b1; bif.res_taken = 1'b0;
    tick();
    bif.pred_valid = 1'b0; bif.res_valid = 1'b0;
    chk("drop_flush", 32'(bif.flush), 1);
    chk("drop_inflight", 32'(inflight), 0);
    chk("drop_redirect", bif.redirect_pc, 32'h34);
    tick();
    chk("drop_inflight_after", 32'(inflight), 0);
    chk("drop_no_underflow", 32'(underflow_err), 0);
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [31:0] epc;
    pulses = 0;
    push(32'h100, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      bif.pred_valid = 1'b1; bif.pred_pc = 32'h104 + 32'(4 * i); bif.pred_taken = 1'b0;
      bif.res_valid = 1'b1; bif.res_taken = 1'b0; bif.res_target = 32'h0;
      tick();
      epc = 32'h100 + 32'(4 * i);
      if (bif.bht_en === 1'b1) pulses++;
      chk("b2b_addr", 32'(bif.bht_write_addr), 32'(epc[6:2]));
      chk("b2b_inflight", 32'(inflight), 1);
      chk("b2b_flush", 32'(bif.flush), 0);
    end
    bif.pred_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 10);
    tick();
    bif.res_valid = 1'b0;
    chk("b2b_drain_addr", 32'(bif.bht_write_addr), 32'h0A);
    chk("b2b_drain_inflight", 32'(inflight), 0);
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push(32'(4 * i), 1'b1, 32'h200);
    chk("full_pred_ready", 32'(bif.pred_ready), 0);
    chk("full_inflight", 32'(inflight), 4);
    bif.pred_valid = 1'b1; bif.pred_pc = 32'h50;
    bif.res_valid = 1'b1; bif.res_taken = 1'b0;
    tick();
    bif.pred_valid = 1'b0;
    chk("full_flush", 32'(bif.flush), 1);
    chk("full_redirect", bif.redirect_pc, 32'h4);
    chk("full_inflight_clr", 32'(inflight), 0);
    chk("full_ready_flush", 32'(bif.pred_ready), 0);
    tick();
    chk("full_flush_blk_bht", 32'(bif.bht_en), 0);
    chk("full_flush_blk_err", 32'(underflow_err), 0);
    tick();
    chk("full_uf_bht", 32'(bif.bht_en), 0);
    chk("full_uf_err", 32'(underflow_err), 1);
    tick();
    bif.res_valid = 1'b0;
    tick();
    chk("full_uf_sticky", 32'(underflow_err), 1);
    chk("full_inflight_end", 32'(inflight), 0);
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("mr_uf_cleared", 32'(underflow_err), 0);
    for (int i = 0; i < 6; i++) begin
      push(32'h300 + 32'(4 * i), 1'b0, 32'h0);
      if (i == 1 || i == 4) begin
        resolve(1'b1, 32'h400);
        tick();
      end else begin
        resolve(1'b0, 32'h0);
      end
    end
`ifdef BRANCH_STATS_EN
    chk("stat_resolved", stat_resolved, 6);
    chk("stat_mispred", stat_mispred, 2);
`endif
    push(32'h500, 1'b1, 32'h600);
    push(32'h504, 1'b1, 32'h600);
    chk("mr_inflight_pre", 32'(inflight), 2);
    rst = 1'b1;
    bif.res_valid = 1'b1; bif.res_taken = 1'b0;
    tick();
    rst = 1'b0; bif.res_valid = 1'b0;
    chk("mr_inflight", 32'(inflight), 0);
    chk("mr_flush", 32'(bif.flush), 0);
    chk("mr_bht_en", 32'(bif.bht_en), 0);
`ifdef BRANCH_STATS_EN
    chk("mr_stat_resolved", stat_resolved, 0);
    chk("mr_stat_mispred", stat_mispred, 0);
`endif
    tick();
    chk("mr_flush_after", 32'(bif.flush), 0);
    chk("mr_ready_after", 32'(bif.pred_ready), 1);
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_back_to_back();
    test_full();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
